// File: rtl/inst_fetch.sv
// Instruction fetch FSM: IDLE -> REQ -> WAIT -> HOLD loop, one instruction held at a time.
// Optional INST_FETCH_MISALIGN_CHECK_EN traps a misaligned next_pc into a sticky FAULT state.
module inst_fetch #(
   parameter logic [31:0] RESET_PC    = 32'h8000_0000,
   parameter int          PATTERN_LEN = 15
) (
   input  logic                   clk,
   input  logic                   rst_n,
   output logic                   imem_req_valid,
   input  logic                   imem_req_ready,
   output logic [31:0]            imem_addr,
   input  logic                   imem_rsp_valid,
   input  logic [31:0]            imem_rsp_data,
   output logic                   inst_valid,
   input  logic                   inst_ready,
   output logic [31:0]            inst,
   output logic [PATTERN_LEN-1:0] pattern,
   output logic [31:0]            pc,
   input  logic [31:0]            next_pc,
   output logic [31:0]            fetch_cnt,
   output logic                   fault
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
   // valid never waits on ready, and the request address holds until accepted.
   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_FAULT
   } state_t;

   state_t state;

   assign imem_addr = pc;
   assign pattern   = PATTERN_LEN'({inst[31:25], inst[14:12], inst[6:2]});

`ifdef INST_FETCH_MISALIGN_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         pc             <= RESET_PC;
         inst           <= '0;
         fetch_cnt      <= '0;
         fault          <= 1'b0;
         imem_req_valid <= 1'b0;
         inst_valid     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               state          <= S_REQ;
               imem_req_valid <= 1'b1;
            end
            S_REQ: begin
               if (imem_req_ready) begin
                  state          <= S_WAIT;
                  imem_req_valid <= 1'b0;
               end
            end
            S_WAIT: begin
               if (imem_rsp_valid) begin
                  inst       <= imem_rsp_data;
                  state      <= S_HOLD;
                  inst_valid <= 1'b1;
               end
            end
            S_HOLD: begin
               if (inst_ready) begin
                  pc         <= next_pc;
                  fetch_cnt  <= fetch_cnt + 32'd1;
                  inst_valid <= 1'b0;
                  // A misaligned target parks the fetcher until reset.
                  if (next_pc[1:0] != 2'b00) begin
                     state <= S_FAULT;
                     fault <= 1'b1;
                  end else begin
                     state          <= S_REQ;
                     imem_req_valid <= 1'b1;
                  end
               end
            end
            S_FAULT: begin
               state <= S_FAULT;
            end
            default: begin
               state          <= S_IDLE;
               imem_req_valid <= 1'b0;
               inst_valid     <= 1'b0;
            end
         endcase
      end
   end
`else
   assign fault = 1'b0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         pc             <= RESET_PC;
         inst           <= '0;
         fetch_cnt      <= '0;
         imem_req_valid <= 1'b0;
         inst_valid     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               state          <= S_REQ;
               imem_req_valid <= 1'b1;
            end
            S_REQ: begin
               if (imem_req_ready) begin
                  state          <= S_WAIT;
                  imem_req_valid <= 1'b0;
               end
            end
            S_WAIT: begin
               if (imem_rsp_valid) begin
                  inst       <= imem_rsp_data;
                  state      <= S_HOLD;
                  inst_valid <= 1'b1;
               end
            end
            S_HOLD: begin
               if (inst_ready) begin
                  // Low bits are dropped so fetches stay word aligned.
                  pc             <= next_pc & 32'hFFFF_FFFC;
                  fetch_cnt      <= fetch_cnt + 32'd1;
                  inst_valid     <= 1'b0;
                  state          <= S_REQ;
                  imem_req_valid <= 1'b1;
               end
            end
            default: begin
               state          <= S_IDLE;
               imem_req_valid <= 1'b0;
               inst_valid     <= 1'b0;
            end
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: scoreboard queues for accepted requests and handed-off
// instructions, checked by a negedge monitor; build with INST_FETCH_MISALIGN_CHECK_EN for the fault path.
module tb_inst_fetch;

   localparam int IW = 32 + 32 + 15 + 32;

   logic        clk;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [14:0] pattern;
   logic [31:0] pc;
   logic [31:0] next_pc;
   logic [31:0] fetch_cnt;
   logic        fault;

   int checks = 0;
   int errors = 0;

   logic [31:0]   req_exp_q[$];
   logic [IW-1:0] inst_exp_q[$];

   inst_fetch dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .pattern        (pattern),
      .pc             (pc),
      .next_pc        (next_pc),
      .fetch_cnt      (fetch_cnt),
      .fault          (fault)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic summary();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         if (imem_req_valid && inst_valid) begin
            errors++;
            $display("FAIL excl: req_valid and inst_valid both 1");
         end
         if (imem_req_valid && imem_req_ready) begin
            checks++;
            if (req_exp_q.size() == 0) begin
               errors++;
               $display("FAIL req_unexpected: addr %h", imem_addr);
            end else begin
               logic [31:0] e;
               e = req_exp_q.pop_front();
               if (imem_addr !== e) begin
                  errors++;
                  $display("FAIL req_addr: got %h expected %h", imem_addr, e);
               end
            end
         end
         if (inst_valid && inst_ready) begin
            checks++;
            if (inst_exp_q.size() == 0) begin
               errors++;
               $display("FAIL inst_unexpected: inst %h", inst);
            end else begin
               logic [IW-1:0] e;
               e = inst_exp_q.pop_front();
               if ({pc, inst, pattern, fetch_cnt} !== e) begin
                  errors++;
                  $display("FAIL handoff: got %h expected %h", {pc, inst, pattern, fetch_cnt}, e);
               end
            end
         end
      end
   end

   initial begin
      #50000;
      errors++;
      $display("FAIL watchdog: run did not complete");
      summary();
      $finish;
   end

   // driver / directed stimulus
   initial begin
      rst_n          = 1'b1;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      inst_ready     = 1'b0;
      next_pc        = '0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
      chk("rst_inst_valid", 64'(inst_valid), 64'd0);
      chk("rst_addr", 64'(imem_addr), 64'h8000_0000);
      chk("rst_fetch_cnt", 64'(fetch_cnt), 64'd0);
      chk("rst_fault", 64'(fault), 64'd0);
      step();
      step();
      rst_n = 1'b1;

      // first fetch, zero-latency memory
      imem_req_ready = 1'b1;
      step();
      chk("s1_req_valid", 64'(imem_req_valid), 64'd1);
      chk("s1_addr", 64'(imem_addr), 64'h8000_0000);
      req_exp_q.push_back(32'h8000_0000);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
      step();
      imem_req_ready = 1'b0;
      chk("s1_wait_req_valid", 64'(imem_req_valid), 64'd0);
      chk("s1_wait_inst_valid", 64'(inst_valid), 64'd0);
      imem_rsp_data = 32'h0000_0513;
      step();
      imem_rsp_valid = 1'b0;
      chk("s1_inst_valid", 64'(inst_valid), 64'd1);
      chk("s1_inst", 64'(inst), 64'h0000_0513);
      chk("s1_pattern", 64'(pattern), 64'(15'b0000000_000_00100));
      chk("s1_pc", 64'(pc), 64'h8000_0000);
      inst_exp_q.push_back({32'h8000_0000, 32'h0000_0513, 15'b0000000_000_00100, 32'd0});
      inst_ready = 1'b1;
      next_pc    = 32'h8000_0004;
      step();
      inst_ready = 1'b0;
      chk("s2_fetch_cnt", 64'(fetch_cnt), 64'd1);
      chk("s2_req_valid", 64'(imem_req_valid), 64'd1);
      chk("s2_addr", 64'(imem_addr), 64'h8000_0004);
      chk("s2_inst_valid", 64'(inst_valid), 64'd0);

      // memory stall; stray rsp and inst_ready in REQ must be ignored
      inst_ready     = 1'b1;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_req_valid", 64'(imem_req_valid), 64'd1);
         chk("stall_addr", 64'(imem_addr), 64'h8000_0004);
         chk("stall_inst_valid", 64'(inst_valid), 64'd0);
      end
      chk("stall_fetch_cnt", 64'(fetch_cnt), 64'd1);
      inst_ready     = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_req_ready = 1'b1;
      req_exp_q.push_back(32'h8000_0004);
      step();
      imem_req_ready = 1'b0;
      chk("s3_wait_req_valid", 64'(imem_req_valid), 64'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("lat_inst_valid", 64'(inst_valid), 64'd0);
         chk("lat_req_valid", 64'(imem_req_valid), 64'd0);
      end
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hFE20_CEE3;
      step();
      chk("s3_inst_valid", 64'(inst_valid), 64'd1);
      chk("s3_pattern", 64'(pattern), 64'(15'b1111111_100_11000));
      inst_exp_q.push_back({32'h8000_0004, 32'hFE20_CEE3, 15'b1111111_100_11000, 32'd1});
      imem_rsp_data = 32'h0000_0000;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("hold_inst", 64'(inst), 64'hFE20_CEE3);
         chk("hold_inst_valid", 64'(inst_valid), 64'd1);
      end
      imem_rsp_valid = 1'b0;
      inst_ready = 1'b1;
      next_pc    = 32'h8000_0006;
      step();
      inst_ready = 1'b0;
      chk("mis_fetch_cnt", 64'(fetch_cnt), 64'd2);
`ifdef INST_FETCH_MISALIGN_CHECK_EN
      chk("mis_fault", 64'(fault), 64'd1);
      chk("mis_pc", 64'(pc), 64'h8000_0006);
      for (int i = 0; i < 3; i++) begin
         chk("fault_req_valid", 64'(imem_req_valid), 64'd0);
         chk("fault_inst_valid", 64'(inst_valid), 64'd0);
         step();
      end
      chk("fault_sticky", 64'(fault), 64'd1);
`else
      chk("mis_fault", 64'(fault), 64'd0);
      chk("mis_req_valid", 64'(imem_req_valid), 64'd1);
      chk("mis_addr", 64'(imem_addr), 64'h8000_0004);
`endif

      // restart, then reset while waiting on a response
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      imem_req_ready = 1'b1;
      req_exp_q.push_back(32'h8000_0000);
      step();
      imem_req_ready = 1'b0;
      chk("r_wait_req_valid", 64'(imem_req_valid), 64'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("r_req_valid", 64'(imem_req_valid), 64'd0);
      chk("r_inst_valid", 64'(inst_valid), 64'd0);
      chk("r_addr", 64'(imem_addr), 64'h8000_0000);
      chk("r_fetch_cnt", 64'(fetch_cnt), 64'd0);
      chk("r_fault", 64'(fault), 64'd0);
      chk("r_inst", 64'(inst), 64'd0);
      step();
      rst_n = 1'b1;
      step();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
      step();
      step();
      imem_rsp_valid = 1'b0;
      chk("stale_inst_valid", 64'(inst_valid), 64'd0);
      chk("stale_req_valid", 64'(imem_req_valid), 64'd1);
      chk("stale_addr", 64'(imem_addr), 64'h8000_0000);

      // counter wrap on handoff
      imem_req_ready = 1'b1;
      req_exp_q.push_back(32'h8000_0000);
      step();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h00B5_4633;
      step();
      imem_rsp_valid = 1'b0;
      chk("w_inst", 64'(inst), 64'h00B5_4633);
      force dut.fetch_cnt = 32'hFFFF_FFFF;
      #1 release dut.fetch_cnt;
      inst_exp_q.push_back({32'h8000_0000, 32'h00B5_4633, 15'b0000000_100_01100, 32'hFFFF_FFFF});
      inst_ready = 1'b1;
      next_pc    = 32'h8000_0010;
      step();
      inst_ready = 1'b0;
      chk("wrap_fetch_cnt", 64'(fetch_cnt), 64'd0);
      chk("wrap_req_valid", 64'(imem_req_valid), 64'd1);
      chk("wrap_addr", 64'(imem_addr), 64'h8000_0010);
      step();
      step();
      chk("req_q_empty", 64'(req_exp_q.size()), 64'd0);
      chk("inst_q_empty", 64'(inst_exp_q.size()), 64'd0);

      summary();
      $finish;
   end

endmodule
